// File: rtl/obc1_oam_reader.sv
// ----------------------------------------------------------------------------
// obc1_oam_reader
//   Walks one OBC1 OAM bank and streams it out as bytes: LOW_BYTES bytes from
//   the lower OAM RAM, then HIGH_BYTES bytes from the upper RAM's byte port.
//   Each byte takes three cycles: FETCH (address on the RAM), CAPTURE (read
//   data registered), PRESENT (held until the sink accepts it).
//
// Ports
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_start      single-cycle dump request (ignored while busy)
//   i_bank_sel   OAM bank to dump, latched on an accepted start
//   o_ram_req    reader owns the RAM read addresses (equals o_busy)
//   o_low_addr   lower RAM address {bank, idx[8:0]}
//   i_low_data   lower RAM read data, valid one cycle after o_low_addr
//   o_high_addr  upper RAM byte-port address {bank, idx[4:0]}
//   i_high_data  upper RAM read data, valid one cycle after o_high_addr
//   o_out_data   streamed byte
//   o_out_valid  o_out_data valid
//   i_out_ready  sink accepts on o_out_valid & i_out_ready
//   o_out_last   marks the final byte of the dump
//   o_busy       dump in progress
//   o_done       one-cycle pulse after the final handshake
// ----------------------------------------------------------------------------
module obc1_oam_reader #(
  parameter int unsigned LOW_BYTES  = 512,
  parameter int unsigned HIGH_BYTES = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_bank_sel,
  output logic                          o_ram_req,
  output logic [$clog2(LOW_BYTES):0]    o_low_addr,
  input  logic [7:0]                    i_low_data,
  output logic [$clog2(HIGH_BYTES):0]   o_high_addr,
  input  logic [7:0]                    i_high_data,
  output logic [7:0]                    o_out_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_out_last,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int unsigned LOW_W  = $clog2(LOW_BYTES);
  localparam int unsigned HIGH_W = $clog2(HIGH_BYTES);
  localparam int unsigned TOTAL  = LOW_BYTES + HIGH_BYTES;
  localparam int unsigned IDX_W  = $clog2(TOTAL);

  localparam logic [IDX_W-1:0] LOW_LIM  = IDX_W'(LOW_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
  logic               r_bank,      w_bank_nxt;
  logic [LOW_W:0]     r_low_addr,  w_low_addr_nxt;
  logic [HIGH_W:0]    r_high_addr, w_high_addr_nxt;
  logic [7:0]         r_out_data,  w_out_data_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_out_last,  w_out_last_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;

  logic [IDX_W-1:0]   w_idx_inc;
  logic               w_cur_low;
  logic               w_inc_low;
  logic               w_handshake;

  assign w_idx_inc   = r_idx + IDX_W'(1);
  assign w_cur_low   = (r_idx < LOW_LIM);
  assign w_inc_low   = (w_idx_inc < LOW_LIM);
  assign w_handshake = r_out_valid & i_out_ready;

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_bank      <= 1'b0;
      r_low_addr  <= '0;
      r_high_addr <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_bank      <= w_bank_nxt;
      r_low_addr  <= w_low_addr_nxt;
      r_high_addr <= w_high_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic. The address for a byte is loaded on
  // the edge entering FETCH, so it sits on the RAM throughout FETCH and the
  // synchronous read data is ready to be registered in CAPTURE.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_bank_nxt      = r_bank;
    w_low_addr_nxt  = r_low_addr;
    w_high_addr_nxt = r_high_addr;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_bank_nxt     = i_bank_sel;
          w_idx_nxt      = '0;
          w_busy_nxt     = 1'b1;
          w_low_addr_nxt = {i_bank_sel, LOW_W'(0)};
          w_state_nxt    = S_FETCH;
        end
      end

      S_FETCH: begin
        w_state_nxt = S_CAPTURE;
      end

      S_CAPTURE: begin
        w_out_data_nxt  = w_cur_low ? i_low_data : i_high_data;
        w_out_valid_nxt = 1'b1;
        w_out_last_nxt  = (r_idx == LAST_IDX);
        w_state_nxt     = S_PRESENT;
      end

      S_PRESENT: begin
        if (w_handshake) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = w_idx_inc;
            w_state_nxt = S_FETCH;
            // Only the address of the source in use moves; the other holds.
            if (w_inc_low) begin
              w_low_addr_nxt  = {r_bank, w_idx_inc[LOW_W-1:0]};
            end else begin
              w_high_addr_nxt = {r_bank, w_idx_inc[HIGH_W-1:0]};
            end
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_ram_req   = r_busy;
  assign o_busy      = r_busy;
  assign o_low_addr  = r_low_addr;
  assign o_high_addr = r_high_addr;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_done      = r_done;

endmodule

// File: tb/tb_obc1_oam_reader.sv
// ----------------------------------------------------------------------------
// tb_obc1_oam_reader
//   Bench for obc1_oam_reader. Provides synchronous-read OAM RAM models and
//   compares the streamed bytes against the bank contents in dump order.
// ----------------------------------------------------------------------------
module tb_obc1_oam_reader;

  localparam int TOTAL = 544;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic       i_bank_sel;
  logic       o_ram_req;
  logic [9:0] o_low_addr;
  logic [7:0] i_low_data;
  logic [5:0] o_high_addr;
  logic [7:0] i_high_data;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       i_out_ready;
  logic       o_out_last;
  logic       o_busy;
  logic       o_done;

  obc1_oam_reader #(.LOW_BYTES(512), .HIGH_BYTES(32)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_bank_sel  (i_bank_sel),
    .o_ram_req   (o_ram_req),
    .o_low_addr  (o_low_addr),
    .i_low_data  (i_low_data),
    .o_high_addr (o_high_addr),
    .i_high_data (i_high_data),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_last  (o_out_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  // RAM models: read data registered one cycle after the address.
  logic [7:0] low_mem  [0:1023];
  logic [7:0] high_mem [0:63];

  always @(posedge i_clk) begin
    i_low_data  <= low_mem[o_low_addr];
    i_high_data <= high_mem[o_high_addr];
  end

  int errors = 0;
  int checks = 0;

  // Observations from one dump.
  logic [7:0] got_q   [$];
  bit         last_q  [$];
  logic [9:0] laddr_q [$];
  logic [5:0] haddr_q [$];
  int         busy_cyc;
  int         first_valid;
  int         done_cyc;
  int         last_hs_cyc;
  int         stall_changes;
  logic [9:0] stall_laddr;
  bit         timeout;

  // Reference: a dump is the bank's lower bytes followed by its upper bytes.
  function automatic logic [7:0] model_byte(input bit bank, input int n);
    if (n < 512) return low_mem[int'(bank) * 512 + n];
    else         return high_mem[int'(bank) * 32 + (n - 512)];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_pattern0();
    for (int a = 0; a < 512; a++) low_mem[a] = 8'(a);
    for (int j = 0; j < 32; j++)  high_mem[j] = 8'(8'hA0 + j);
  endtask

  task automatic fill_random(input bit bank);
    for (int a = 0; a < 512; a++) low_mem[int'(bank) * 512 + a] = 8'($urandom);
    for (int j = 0; j < 32; j++)  high_mem[int'(bank) * 32 + j] = 8'($urandom);
  endtask

  task automatic start_dump(input bit bank);
    i_bank_sel = bank;
    i_start    = 1'b1;
    step();
    i_start    = 1'b0;
  endtask

  // Drives the sink side of one dump (entered on the cycle after the start
  // edge) and records what was handed over. Returns on the done cycle.
  task automatic collect(input int stall_byte, input int stall_len, input bit mutate,
                         input int poke_byte, input bit rand_ready);
    int cyc = 0;
    int stall_cnt = 0;
    logic [7:0] ref_d = '0;
    logic       ref_l = 1'b0;
    logic [9:0] ref_a = '0;
    got_q.delete(); last_q.delete(); laddr_q.delete(); haddr_q.delete();
    busy_cyc = 0; first_valid = -1; done_cyc = -1; last_hs_cyc = -1;
    stall_changes = 0; stall_laddr = '0; timeout = 1'b0;
    forever begin
      if (o_busy) busy_cyc++;
      if (o_out_valid && first_valid < 0) first_valid = cyc;
      if (o_done) begin
        done_cyc    = cyc;
        i_out_ready = 1'b1;
        return;
      end
      i_start     = 1'b0;
      i_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (o_out_valid && int'(got_q.size()) == stall_byte) begin
        if (stall_cnt == 0) begin
          ref_d = o_out_data; ref_l = o_out_last; ref_a = o_low_addr;
          stall_laddr = o_low_addr;
          if (mutate) low_mem[o_low_addr] = ~low_mem[o_low_addr];
        end else if (o_out_data !== ref_d || o_out_last !== ref_l || o_low_addr !== ref_a) begin
          stall_changes++;
        end
        if (stall_cnt < stall_len) begin
          i_out_ready = 1'b0;
          stall_cnt++;
        end else begin
          i_out_ready = 1'b1;
        end
      end
      if (o_out_valid && i_out_ready) begin
        if (int'(got_q.size()) == poke_byte) begin
          i_start    = 1'b1;
          i_bank_sel = ~i_bank_sel;
        end
        got_q.push_back(o_out_data);
        last_q.push_back(o_out_last);
        laddr_q.push_back(o_low_addr);
        haddr_q.push_back(o_high_addr);
        if (got_q.size() == TOTAL) last_hs_cyc = cyc;
      end
      step();
      cyc++;
      if (cyc > 6000) begin
        timeout = 1'b1;
        i_start = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b1; i_bank_sel = 1'b1; i_out_ready = 1'b1;
    step(); step(); step();
    checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_ram_req !== 1'b0)   begin errors++; $display("FAIL reset_ram_req got=%b exp=0", o_ram_req); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_out_valid); end
    checks++; if (o_out_last !== 1'b0)  begin errors++; $display("FAIL reset_last got=%b exp=0", o_out_last); end
    checks++; if (o_done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", o_out_data); end
    checks++; if (o_low_addr !== 10'h0) begin errors++; $display("FAIL reset_low_addr got=%h exp=000", o_low_addr); end
    checks++; if (o_high_addr !== 6'h0) begin errors++; $display("FAIL reset_high_addr got=%h exp=00", o_high_addr); end
    i_start = 1'b0; i_reset = 1'b0;
    step();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_stays got=%b exp=0", o_busy); end
  endtask

  task automatic test_bank0_dump();
    int bad = 0;
    fill_pattern0();
    start_dump(1'b0);
    collect(-1, 0, 1'b0, -1, 1'b0);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL b0_timeout got=%b exp=0", timeout); end
    checks++; if (got_q.size() != TOTAL) begin errors++; $display("FAIL b0_count got=%0d exp=%0d", got_q.size(), TOTAL); end
    if (got_q.size() == TOTAL) begin
      checks++; if (got_q[0] !== 8'h00)   begin errors++; $display("FAIL b0_byte0 got=%h exp=00", got_q[0]); end
      checks++; if (got_q[511] !== 8'hFF) begin errors++; $display("FAIL b0_byte511 got=%h exp=ff", got_q[511]); end
      checks++; if (got_q[512] !== 8'hA0) begin errors++; $display("FAIL b0_byte512 got=%h exp=a0", got_q[512]); end
      checks++; if (got_q[543] !== 8'hBF) begin errors++; $display("FAIL b0_byte543 got=%h exp=bf", got_q[543]); end
      for (int n = 0; n < TOTAL; n++) begin
        if (got_q[n] !== model_byte(1'b0, n) || last_q[n] !== (n == TOTAL - 1)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b0_stream_last bad_bytes=%0d exp=0", bad); end
    end
    checks++; if (busy_cyc != 1632)   begin errors++; $display("FAIL b0_busy_cycles got=%0d exp=1632", busy_cyc); end
    checks++; if (first_valid != 2)   begin errors++; $display("FAIL b0_first_valid got=%0d exp=2", first_valid); end
    checks++; if (last_hs_cyc != 1631) begin errors++; $display("FAIL b0_last_handshake got=%0d exp=1631", last_hs_cyc); end
    checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("FAIL b0_done_time got=%0d exp=%0d", done_cyc, last_hs_cyc + 1); end
    step();
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL b0_done_width got=%b exp=0", o_done); end
  endtask

  task automatic test_bank1_addr();
    int bad_d = 0;
    int bad_a = 0;
    fill_random(1'b1);
    start_dump(1'b1);
    i_bank_sel = 1'b0;
    collect(-1, 0, 1'b0, -1, 1'b0);
    checks++; if (got_q.size() != TOTAL || timeout) begin errors++; $display("FAIL b1_count got=%0d exp=%0d", got_q.size(), TOTAL); end
    if (got_q.size() == TOTAL) begin
      for (int n = 0; n < TOTAL; n++) begin
        if (got_q[n] !== model_byte(1'b1, n)) bad_d++;
        if (n < 512) begin
          if (laddr_q[n] !== 10'(512 + n)) bad_a++;
        end else begin
          if (haddr_q[n] !== 6'(32 + n - 512) || laddr_q[n] !== 10'h3FF) bad_a++;
        end
      end
      checks++; if (bad_d != 0) begin errors++; $display("FAIL b1_stream bad_bytes=%0d exp=0", bad_d); end
      checks++; if (bad_a != 0) begin errors++; $display("FAIL b1_addresses bad_addrs=%0d exp=0", bad_a); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q [$];
    int bad = 0;
    fill_pattern0();
    for (int n = 0; n < TOTAL; n++) exp_q.push_back(model_byte(1'b0, n));
    start_dump(1'b0);
    collect(100, 5, 1'b1, -1, 1'b0);
    low_mem[stall_laddr] = ~low_mem[stall_laddr];
    checks++; if (got_q.size() != TOTAL || timeout) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), TOTAL); end
    if (got_q.size() == TOTAL) begin
      for (int n = 0; n < TOTAL; n++) if (got_q[n] !== exp_q[n]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_stream bad_bytes=%0d exp=0", bad); end
    end
    checks++; if (stall_changes != 0)  begin errors++; $display("FAIL bp_stable changes=%0d exp=0", stall_changes); end
    checks++; if (stall_laddr !== 10'd100) begin errors++; $display("FAIL bp_low_addr got=%0d exp=100", stall_laddr); end
    checks++; if (busy_cyc != 1637)    begin errors++; $display("FAIL bp_busy_cycles got=%0d exp=1637", busy_cyc); end
  endtask

  task automatic test_start_while_busy();
    int bad = 0;
    int extra = 0;
    fill_pattern0();
    start_dump(1'b0);
    collect(-1, 0, 1'b0, 50, 1'b0);
    checks++; if (got_q.size() != TOTAL || timeout) begin errors++; $display("FAIL sb_count got=%0d exp=%0d", got_q.size(), TOTAL); end
    if (got_q.size() == TOTAL) begin
      for (int n = 0; n < TOTAL; n++) if (got_q[n] !== model_byte(1'b0, n)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL sb_stream bad_bytes=%0d exp=0", bad); end
    end
    checks++; if (busy_cyc != 1632) begin errors++; $display("FAIL sb_busy_cycles got=%0d exp=1632", busy_cyc); end
    for (int k = 0; k < 6; k++) begin
      step();
      if (o_done || o_busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL sb_single_done extra_cycles=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cyc = 0;
    logic [7:0] save0;
    fill_pattern0();
    save0 = low_mem[0];
    low_mem[0] = 8'h5A;
    start_dump(1'b0);
    i_out_ready = 1'b1;
    while (!(o_out_valid && n == 300) && cyc < 3000) begin
      if (o_out_valid) n++;
      step();
      cyc++;
    end
    checks++; if (o_out_data !== model_byte(1'b0, 300)) begin errors++; $display("FAIL rm_byte300 got=%h exp=%h", o_out_data, model_byte(1'b0, 300)); end
    i_out_ready = 1'b0;
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_out_ready = 1'b1;
    checks++; if (o_busy !== 1'b0 || o_ram_req !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b/%b exp=0/0", o_busy, o_ram_req); end
    checks++; if (o_out_valid !== 1'b0 || o_out_last !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b/%b exp=0/0", o_out_valid, o_out_last); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rm_done got=%b exp=0", o_done); end
    checks++; if (o_low_addr !== 10'h0 || o_out_data !== 8'h00) begin errors++; $display("FAIL rm_regs got=%h/%h exp=000/00", o_low_addr, o_out_data); end
    step();
    checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rm_no_done got=%b/%b exp=0/0", o_done, o_busy); end
    start_dump(1'b0);
    cyc = 0;
    while (!o_out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    checks++; if (o_out_valid !== 1'b1 || cyc != 2) begin errors++; $display("FAIL rm_restart_latency got=%0d exp=2", cyc); end
    checks++; if (o_out_data !== 8'h5A || o_low_addr !== 10'h0) begin errors++; $display("FAIL rm_restart_byte got=%h@%h exp=5a@000", o_out_data, o_low_addr); end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    low_mem[0] = save0;
    step();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    fill_pattern0();
    fill_random(1'b1);
    start_dump(1'b0);
    collect(-1, 0, 1'b0, -1, 1'b0);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL bb_first_done got=%b exp=1", o_done); end
    start_dump(1'b1);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL bb_accept got=%b exp=1", o_busy); end
    collect(-1, 0, 1'b0, -1, 1'b0);
    checks++; if (first_valid != 2) begin errors++; $display("FAIL bb_first_valid got=%0d exp=2", first_valid); end
    checks++; if (got_q.size() != TOTAL || timeout) begin errors++; $display("FAIL bb_count got=%0d exp=%0d", got_q.size(), TOTAL); end
    if (got_q.size() == TOTAL) begin
      checks++; if (got_q[0] !== model_byte(1'b1, 0)) begin errors++; $display("FAIL bb_byte0 got=%h exp=%h", got_q[0], model_byte(1'b1, 0)); end
      for (int n = 0; n < TOTAL; n++) if (got_q[n] !== model_byte(1'b1, n)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bb_stream bad_bytes=%0d exp=0", bad); end
    end
    step();
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      bit bank;
      int bad = 0;
      int lasts = 0;
      bank = 1'($urandom);
      fill_random(bank);
      start_dump(bank);
      i_bank_sel = 1'($urandom);
      collect(-1, 0, 1'b0, -1, 1'b1);
      checks++; if (got_q.size() != TOTAL || timeout) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, got_q.size(), TOTAL); end
      if (got_q.size() == TOTAL) begin
        for (int n = 0; n < TOTAL; n++) begin
          if (got_q[n] !== model_byte(bank, n)) bad++;
          if (last_q[n]) lasts++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_stream bad_bytes=%0d exp=0", r, bad); end
        checks++; if (lasts != 1 || last_q[TOTAL-1] !== 1'b1) begin errors++; $display("FAIL rnd%0d_last count=%0d exp=1", r, lasts); end
      end
      checks++; if (busy_cyc < 1632) begin errors++; $display("FAIL rnd%0d_busy got=%0d exp>=1632", r, busy_cyc); end
      step();
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_bank_sel = 1'b0; i_out_ready = 1'b1;
    fill_pattern0();
    fill_random(1'b1);
    test_reset();
    test_bank0_dump();
    test_bank1_addr();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obc1_oam_reader.md
Name: obc1_oam_reader

Overview:
Sequential reader for the OBC1 OAM buffer. On command it walks one OAM bank: 512 bytes from the lower RAM, then 32 bytes from the upper RAM's byte-wide port. It streams the 544 bytes out over a valid/ready byte interface for MCU-side dump or savestate. It is the consumer end of the buffer that the OBC1 register/SNES write path fills. It sits beside the OBC1 core, and the top level muxes the RAM read addresses to this block while ram_req is high.

Parameters:
LOW_BYTES, 512, bytes per bank in lower OAM RAM (index width 9)
HIGH_BYTES, 32, bytes per bank in upper OAM RAM (index width 5)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle dump request
bank_sel  input  1  OAM bank to dump, used directly as RAM address MSB
ram_req  output  1  high while the reader owns the RAM read addresses
low_addr  output  10  lower RAM address {bank, idx[8:0]}
low_data  input  8  lower RAM read data, valid 1 cycle after low_addr
high_addr  output  6  upper RAM byte-port address {bank, idx[4:0]}
high_data  input  8  upper RAM byte-port read data, valid 1 cycle after high_addr
out_data  output  8  streamed byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts byte when out_valid & out_ready
out_last  output  1  qualifies final byte (index 543)
busy  output  1  dump in progress
done  output  1  1-cycle pulse after the final handshake

Behaviour:
- Reset (synchronous, wins over all other inputs): state=IDLE, idx=0, bank latch=0. Outputs ram_req, busy, out_valid, out_last and done are 0; out_data, low_addr and high_addr are 0.
- idx is a 10-bit counter over 0..543. idx<512 selects the lower source; idx>=512 selects the upper source, using idx-512 (idx[4:0]).
- bank_sel is latched on accepted start. Later changes are ignored until the next dump.
- ram_req = busy. Address outputs are registered and change only in FETCH.
- FSM states:
  - IDLE: start=1 -> latch bank, idx=0, busy=1, go FETCH. start=0 -> stay.
  - FETCH: drive low_addr or high_addr for idx (the unused address holds its last value), go CAPTURE.
  - CAPTURE: register low_data or high_data into out_data; set out_valid=1; out_last=(idx==543); go PRESENT.
  - PRESENT: out_data, out_valid and out_last are held stable while out_ready=0.
    - Handshake and idx<543: out_valid=0, out_last=0, idx+1, go FETCH.
    - Handshake and idx==543: out_valid=0, out_last=0, busy=0, done=1 for exactly the next cycle, go IDLE.
- Throughput: 3 cycles per byte with out_ready held high; a full dump is 1632 cycles from start to final handshake.
- The first out_valid rises 2 cycles after the start cycle (FETCH, then CAPTURE registers the data).
- start while busy: ignored, with no restart and no latch update.
- start in the same cycle as done=1: accepted; a new dump begins.
- out_ready while out_valid=0: no effect.
- Reset mid-dump: all outputs return to reset values on the next edge. No done pulse. A later start begins again at idx 0.
- Data is captured into a register, so RAM writes after CAPTURE do not alter the presented byte.

Test Plan:
- Bank 0 dump, out_ready=1, low RAM preloaded with byte i at addr i and high RAM with 0xA0+j at addr j:
  - 544 bytes out; byte 0=0x00, byte 511=0xFF, byte 512=0xA0, byte 543=0xBF.
  - out_last only on byte 543; done is high one cycle after its handshake; busy is high for 1632 cycles.
- Bank 1 dump (bank_sel=1, toggled to 0 after start): low_addr sequence 0x200..0x3FF, then high_addr 0x20..0x3F; the toggle has no effect.
- Backpressure: drop out_ready for 5 cycles at byte 100 -> out_data and out_last stable, low_addr stays at 100, no duplicate or skipped bytes; total handshakes remain 544.
- start pulse at byte 50 while busy -> ignored; the stream continues at byte 51 and exactly one done pulse is produced.
- Reset asserted while byte 300 is in PRESENT -> busy, out_valid and done are 0 next cycle. A new start yields first byte = low RAM addr 0.
- start in the same cycle as done -> second dump starts; out_valid rises 2 cycles later with byte 0.
